// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle datapath front end:
// move encoding, move stat tables and GARO lane seeding.
package pbs_pkg;

  typedef logic [1:0] move_t;

  localparam int N_LANES = 6;

  localparam logic [15:0] POLY      = 16'hB400;
  localparam logic [15:0] SEED_BASE = 16'h1D2B;
  localparam logic [15:0] SEED_STEP = 16'h9E37;
  localparam logic [15:0] SEED_ALT  = 16'hACE1;

  localparam logic [4:0] DMG_TBL [4] = '{
    5'd3, 5'd5, 5'd7, 5'd10
  };
  localparam logic [4:0] ACC_TBL [4] = '{
    5'd15, 5'd12, 5'd8, 5'd4
  };

  // An all-zero seed would lock the LFSR, so swap it out.
  function automatic logic [15:0] lane_seed(
    input int k
  );
    logic [15:0] s;
    s = SEED_BASE ^ 16'(k * int'(SEED_STEP));
    if (s == 16'h0000) s = SEED_ALT;
    return s;
  endfunction

endpackage

// File: rtl/garo_lane.sv
// One emulated GARO bit source: a 16-bit Galois LFSR
// that can be frozen, with its low bit as the random output.
module garo_lane
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_ALT
) (
  input  logic clk,
  input  logic rst,
  input  logic stop,
  output logic rnd
);

  logic [15:0] s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= SEED;
    end else if (!stop) begin
      s <= (s >> 1) ^ (s[0] ? POLY : 16'h0000);
    end
  end

  assign rnd = s[0];

endmodule

// File: rtl/garo_move_mux.sv
// Move select and randomness front end: six GARO lanes,
// trainer mux, move stat table and the hit compare.
module garo_move_mux
  import pbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       actr,
  input  logic [1:0] p_move,
  output logic [1:0] ai_move,
  output logic [4:0] accu_rng,
  output logic [4:0] dmg,
  output logic [4:0] accu,
  output logic       hit
);

  logic [N_LANES-1:0] bits;
  move_t              sel;
  logic [4:0]         tbl_dmg;
  logic [4:0]         tbl_acc;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    garo_lane #(
      .SEED (lane_seed(k))
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .stop (stop),
      .rnd  (bits[k])
    );
  end

  assign ai_move  = bits[1:0];
  assign accu_rng = {1'b0, bits[5:2]};
  assign hit      = (accu >= accu_rng);

  always_comb begin
    tbl_dmg = DMG_TBL[0];
    tbl_acc = ACC_TBL[0];
    unique case (sel)
      2'd0: begin
        tbl_dmg = DMG_TBL[0];
        tbl_acc = ACC_TBL[0];
      end
      2'd1: begin
        tbl_dmg = DMG_TBL[1];
        tbl_acc = ACC_TBL[1];
      end
      2'd2: begin
        tbl_dmg = DMG_TBL[2];
        tbl_acc = ACC_TBL[2];
      end
      2'd3: begin
        tbl_dmg = DMG_TBL[3];
        tbl_acc = ACC_TBL[3];
      end
      default: ;
    endcase
  end

  // Pipeline keeps moving while lanes are frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel  <= 2'd0;
      dmg  <= 5'd0;
      accu <= 5'd0;
    end else begin
      sel  <= actr ? ai_move : p_move;
      dmg  <= tbl_dmg;
      accu <= tbl_acc;
    end
  end

endmodule

// File: tb/tb_garo_move_mux.sv
// Scoreboard bench for garo_move_mux: stimulus pushes
// expected values, a negedge monitor pops and compares.
module tb_garo_move_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       actr;
  logic [1:0] p_move;
  logic [1:0] ai_move;
  logic [4:0] accu_rng;
  logic [4:0] dmg;
  logic [4:0] accu;
  logic       hit;
  logic       t_rnd;

  always #5 clk = ~clk;

  garo_move_mux dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .actr     (actr),
    .p_move   (p_move),
    .ai_move  (ai_move),
    .accu_rng (accu_rng),
    .dmg      (dmg),
    .accu     (accu),
    .hit      (hit)
  );

  garo_lane #(
    .SEED (16'h0001)
  ) u_lane (
    .clk  (clk),
    .rst  (rst),
    .stop (stop),
    .rnd  (t_rnd)
  );

  localparam int K_DMG  = 0;
  localparam int K_ACC  = 1;
  localparam int K_AI   = 2;
  localparam int K_RNG  = 3;
  localparam int K_HIT  = 4;
  localparam int K_TL   = 5;
  localparam int K_DL   = 6;
  localparam int K_SEL  = 7;
  localparam int K_TBIT = 8;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string phase = "init";

  // Hand-computed seeds: 16'h1D2B ^ (k*16'h9E37) mod 2^16.
  logic [15:0] seeds [6] = '{
    16'h1D2B, 16'h831C, 16'h2145,
    16'hC78E, 16'h65F7, 16'h0A38
  };

  logic [15:0] m [6];
  logic [1:0]  m_sel;
  logic [4:0]  m_dmg;
  logic [4:0]  m_acc;

  function automatic logic [4:0] t_dmg(input logic [1:0] s);
    case (s)
      2'd0:    return 5'd3;
      2'd1:    return 5'd5;
      2'd2:    return 5'd7;
      default: return 5'd10;
    endcase
  endfunction

  function automatic logic [4:0] t_acc(input logic [1:0] s);
    case (s)
      2'd0:    return 5'd15;
      2'd1:    return 5'd12;
      2'd2:    return 5'd8;
      default: return 5'd4;
    endcase
  endfunction

  function automatic logic [1:0] m_ai();
    return {m[1][0], m[0][0]};
  endfunction

  function automatic logic [4:0] m_rng();
    return {1'b0, m[5][0], m[4][0], m[3][0], m[2][0]};
  endfunction

  function automatic logic [15:0] dlane(input int k);
    case (k)
      0:       return dut.g_lane[0].u_lane.s;
      1:       return dut.g_lane[1].u_lane.s;
      2:       return dut.g_lane[2].u_lane.s;
      3:       return dut.g_lane[3].u_lane.s;
      4:       return dut.g_lane[4].u_lane.s;
      default: return dut.g_lane[5].u_lane.s;
    endcase
  endfunction

  function automatic logic [15:0] actual(input item_t it);
    case (it.kind)
      K_DMG:   return {11'd0, dmg};
      K_ACC:   return {11'd0, accu};
      K_AI:    return {14'd0, ai_move};
      K_RNG:   return {11'd0, accu_rng};
      K_HIT:   return {15'd0, hit};
      K_TL:    return u_lane.s;
      K_DL:    return dlane(it.idx);
      K_SEL:   return {14'd0, dut.sel};
      default: return {15'd0, t_rnd};
    endcase
  endfunction

  task automatic push(
    input int kind, input int idx,
    input logic [15:0] e, input string nm
  );
    item_t it;
    it.kind = kind;
    it.idx  = idx;
    it.exp  = e;
    it.name = {phase, ".", nm};
    q.push_back(it);
  endtask

  task automatic push_outs();
    logic [4:0] r;
    r = m_rng();
    push(K_DMG, 0, {11'd0, m_dmg}, "dmg");
    push(K_ACC, 0, {11'd0, m_acc}, "accu");
    push(K_AI,  0, {14'd0, m_ai()}, "ai_move");
    push(K_RNG, 0, {11'd0, r}, "accu_rng");
    push(K_HIT, 0, {15'd0, m_acc >= r}, "hit");
  endtask

  // Drive one cycle, advance the model as the edge will, expect.
  task automatic step(
    input logic r, input logic st,
    input logic ac, input logic [1:0] pm
  );
    rst = r; stop = st; actr = ac; p_move = pm;
    if (!r) begin
      for (int k = 0; k < 6; k++) m[k] = seeds[k];
      m_sel = 2'd0;
      m_dmg = 5'd0;
      m_acc = 5'd0;
    end else begin
      m_dmg = t_dmg(m_sel);
      m_acc = t_acc(m_sel);
      m_sel = ac ? m_ai() : pm;
      if (!st) begin
        for (int k = 0; k < 6; k++)
          m[k] = (m[k] >> 1) ^ (m[k][0] ? 16'hB400 : 16'h0);
      end
    end
    @(posedge clk);
    #1;
    push_outs();
  endtask

  task automatic push_reset_state();
    for (int k = 0; k < 6; k++)
      push(K_DL, k, seeds[k], $sformatf("lane%0d", k));
    push(K_SEL, 0, 16'd0, "sel");
  endtask

  always @(negedge clk) begin
    item_t it;
    logic [15:0] a;
    while (q.size() > 0) begin
      it = q.pop_front();
      a  = actual(it);
      n_vec++;
      if (a !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h",
                 it.name, a, it.exp);
      end
    end
  end

  initial begin
    int f8;
    int f9;
    rst = 1'b0; stop = 1'b0; actr = 1'b0; p_move = 2'd0;

    phase = "reset";
    step(1'b0, 1'b0, 1'b0, 2'd0);
    push_reset_state();
    push(K_TL, 0, 16'h0001, "tlane");
    push(K_AI, 0, 16'd1, "ai_const");
    push(K_RNG, 0, 16'd5, "rng_const");

    phase = "lane";
    step(1'b1, 1'b0, 1'b0, 2'd0);
    push(K_TL, 0, 16'hB400, "tlane1");
    push(K_TBIT, 0, 16'd0, "tbit1");
    step(1'b1, 1'b0, 1'b0, 2'd0);
    push(K_TL, 0, 16'h5A00, "tlane2");

    phase = "player";
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 2'(i));
    step(1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 1'b0, 1'b0, 2'd3);

    phase = "stop";
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, 2'(i % 4));
    phase = "resume";
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 2'd1);

    phase = "ai";
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b0, 1'b1, 2'd0);

    phase = "midrst";
    step(1'b0, 1'b1, 1'b1, 2'd3);
    push_reset_state();
    step(1'b1, 1'b0, 1'b0, 2'd2);

    phase = "hit";
    f8 = 0;
    f9 = 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd2);
      if (m_acc == 5'd8 && m_rng() == 5'd8) f8++;
      if (m_acc == 5'd8 && m_rng() == 5'd9) f9++;
      if (f8 > 0 && f9 > 0) break;
    end
    if (f8 == 0 || f9 == 0) begin
      n_bad++;
      $display("FAIL hit.cover: roll8=%0d roll9=%0d, need >0",
               f8, f9);
    end

    phase = "hit0";
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b0, 1'b0, 2'd0);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
